piso_serializer: RTL

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB first, with a qualifying valid strobe. It drives the serial side of the team's flop-based serial links, where the matching shift-register receiver reassembles the words. It supports zero-bubble back-to-back words and an optional even-parity bit per word.

---
 rtl/piso_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it MSB first,
// one bit per clock, with ser_valid qualifying each serial bit.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit per word.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no word in flight, ready for a new word
// SHIFT  | data bits going out, cnt = data bits left after this one
// PARITY | parity bit going out (only with PISO_PARITY_EN)

module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  logic last_bit;
  logic final_bit;
  logic accept;

  // Final serial cycle of a word is where the next word may be taken with no bubble.
  assign last_bit = (state == SHIFT) && (cnt == '0);
`ifdef PISO_PARITY_EN
  assign final_bit = (state == PARITY);
`else
  assign final_bit = last_bit;
`endif

  assign in_ready = !rst && ((state == IDLE) || final_bit);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Single FSM register block; a handshake always wins over the default next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
        end
        SHIFT: begin
          sh <= sh << 1;
`ifdef PISO_PARITY_EN
          par <= par ^ sh[WIDTH-1];
`endif
          if (cnt != '0) begin
            cnt     <= cnt - CW'(1);
            ser_out <= sh[WIDTH-2];
          end else begin
`ifdef PISO_PARITY_EN
            state     <= PARITY;
            ser_out   <= par ^ sh[WIDTH-1];
            ser_valid <= 1'b1;
`else
            state     <= IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state     <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
        end
`endif
        default: begin
          state     <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
        end
      endcase

      if (accept) begin
        state     <= SHIFT;
        sh        <= in_data;
        cnt       <= CW'(WIDTH - 1);
        ser_out   <= in_data[WIDTH-1];
        ser_valid <= 1'b1;
`ifdef PISO_PARITY_EN
        par       <= 1'b0;
`endif
      end
    end
  end

endmodule
